// File: rtl/sig_pkg.sv
// Shared types and constants for the out_data signature capture stage.
// Holds the FSM state enum, the sample width and the default MISR polynomial.
package sig_pkg;

  localparam int WIDTH = 96;

  localparam logic [WIDTH-1:0] POLY_DEF =
    96'h40000000_00028000_00000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/misr_reg.sv
// WIDTH-bit MISR register: load seeds it, step folds one sample in.
// Ports: clkin, rst_n, load/seed, step/data, sig (registered state).
module misr_reg #(
  parameter int              WIDTH = sig_pkg::WIDTH,
  parameter logic [WIDTH-1:0] POLY = sig_pkg::POLY_DEF
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] fb;
  logic [WIDTH-1:0] nxt;

  assign fb  = sig[WIDTH-1] ? POLY : '0;
  assign nxt = {sig[WIDTH-2:0], 1'b0} ^ fb ^ data;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= seed;
    end else if (step) begin
      sig <= nxt;
    end
  end

endmodule

// File: rtl/out_signature_misr.sv
// Compacts a programmed number of out_data samples into a MISR signature,
// counts rises of out_data[0], and offers both via valid/ready.
// Ports: clkin, rst_n, start_i/len_i/seed_i, data_valid_i/data_i,
//        sig_valid_o/sig_ready_i/sig_o, rise_cnt_o, busy_o.
module out_signature_misr #(
  parameter int               WIDTH = sig_pkg::WIDTH,
  parameter int               CNT_W = 16,
  parameter logic [WIDTH-1:0] POLY  = sig_pkg::POLY_DEF
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             data_valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             sig_valid_o,
  input  logic             sig_ready_i,
  output logic [WIDTH-1:0] sig_o,
  output logic [CNT_W-1:0] rise_cnt_o,
  output logic             busy_o
);

  import sig_pkg::*;

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rise_q;
  logic             prev_q;
  logic             load;
  logic             step;
  logic             rise;

  assign load = (state_q == S_IDLE) && start_i;
  assign step = (state_q == S_RUN) && data_valid_i;
  assign rise = data_i[0] && !prev_q;

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clkin (clkin),
    .rst_n (rst_n),
    .load  (load),
    .seed  (seed_i),
    .step  (step),
    .data  (data_i),
    .sig   (sig_o)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      rise_q  <= '0;
      prev_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rem_q   <= len_i;
            rise_q  <= '0;
            prev_q  <= 1'b0;
            state_q <= (len_i == '0) ? S_HOLD : S_RUN;
          end
        end
        S_RUN: begin
          if (data_valid_i) begin
            prev_q <= data_i[0];
            rem_q  <= rem_q - CNT_W'(1);
            if (rise && (rise_q != '1)) begin
              rise_q <= rise_q + CNT_W'(1);
            end
            if (rem_q == CNT_W'(1)) begin
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (sig_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs depend on registers only.
  assign sig_valid_o = (state_q == S_HOLD);
  assign busy_o      = (state_q != S_IDLE);
  assign rise_cnt_o  = rise_q;

endmodule

// File: tb/tb_out_signature_misr.sv
// Scoreboard bench for out_signature_misr with a polynomial reference model.
// Directed runs from the test plan plus randomized runs.
module tb_out_signature_misr;

  localparam int W  = 96;
  localparam int CW = 16;
  localparam logic [W-1:0] P = 96'h40000000_00028000_00000001;

  logic          clkin = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [CW-1:0] len_i;
  logic [W-1:0]  seed_i;
  logic          data_valid_i;
  logic [W-1:0]  data_i;
  logic          sig_valid_o;
  logic          sig_ready_i;
  logic [W-1:0]  sig_o;
  logic [CW-1:0] rise_cnt_o;
  logic          busy_o;

  out_signature_misr dut (
    .clkin        (clkin),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .len_i        (len_i),
    .seed_i       (seed_i),
    .data_valid_i (data_valid_i),
    .data_i       (data_i),
    .sig_valid_o  (sig_valid_o),
    .sig_ready_i  (sig_ready_i),
    .sig_o        (sig_o),
    .rise_cnt_o   (rise_cnt_o),
    .busy_o       (busy_o)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [W-1:0]  sig;
    logic [CW-1:0] rise;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] smp_q[$];
  int           gap_q[$];
  int           n_chk = 0;
  int           n_fail = 0;

  logic [W-1:0] m_sig;
  int           m_rise;
  bit           m_prev;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Multiply the signature polynomial by x modulo
  // x^96+x^94+x^49+x^47+1, then add the sample.
  function automatic logic [W-1:0] gf_fold(logic [W-1:0] s,
                                           logic [W-1:0] d);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ {1'b1, P};
    return t[W-1:0] ^ d;
  endfunction

  function automatic logic [W-1:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  always @(negedge clkin) begin
    if (rst_n && sig_valid_o && sig_ready_i) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_sig: got %h, expected none", sig_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_sig", sig_o, e.sig);
        chk("sb_rise", W'(rise_cnt_o), W'(e.rise));
      end
    end
  end

  task automatic run(logic [W-1:0] seed, int len, int hold);
    logic [W-1:0] d;
    int g;
    exp_t e;
    m_sig  = seed;
    m_rise = 0;
    m_prev = 1'b0;
    @(posedge clkin); #1;
    start_i = 1'b1;
    len_i   = CW'(len);
    seed_i  = seed;
    @(posedge clkin); #1;
    start_i = 1'b0;
    for (int k = 0; k < len; k++) begin
      g = (gap_q.size() != 0) ? gap_q.pop_front() : int'($urandom_range(0, 2));
      repeat (g) begin
        data_valid_i = 1'b0;
        data_i = rnd96();
        start_i = $urandom_range(0, 1);
        @(posedge clkin); #1;
      end
      start_i = 1'b0;
      d = (smp_q.size() != 0) ? smp_q.pop_front() : rnd96();
      data_valid_i = 1'b1;
      data_i = d;
      m_sig = gf_fold(m_sig, d);
      if (d[0] && !m_prev && m_rise < 65535) m_rise++;
      m_prev = d[0];
      @(posedge clkin); #1;
    end
    data_valid_i = 1'b0;
    e.sig  = m_sig;
    e.rise = CW'(m_rise);
    sb_q.push_back(e);
    @(negedge clkin);
    chk("latency_valid", W'(sig_valid_o), W'(1));
    @(posedge clkin); #1;
    for (int h = 0; h < hold; h++) begin
      start_i = 1'b1;
      data_valid_i = 1'b1;
      data_i = rnd96();
      @(negedge clkin);
      chk("hold_valid", W'(sig_valid_o), W'(1));
      chk("hold_sig", sig_o, m_sig);
      @(posedge clkin); #1;
    end
    sig_ready_i = 1'b1;
    @(posedge clkin); #1;
    sig_ready_i = 1'b0;
    start_i = 1'b0;
    data_valid_i = 1'b0;
    @(negedge clkin);
    chk("post_valid", W'(sig_valid_o), W'(0));
    chk("post_busy", W'(busy_o), W'(0));
    chk("post_sig", sig_o, m_sig);
  endtask

  initial begin
    bit bad;
    rst_n = 1'b0;
    start_i = 1'b0;
    len_i = '0;
    seed_i = '0;
    data_valid_i = 1'b0;
    data_i = '0;
    sig_ready_i = 1'b0;
    repeat (3) @(posedge clkin);
    #1 rst_n = 1'b1;
    @(negedge clkin);
    chk("rst_sig", sig_o, '0);
    chk("rst_rise", W'(rise_cnt_o), '0);
    chk("rst_valid", W'(sig_valid_o), '0);
    chk("rst_busy", W'(busy_o), '0);
    bad = 1'b0;
    repeat (5) begin
      @(posedge clkin); #1;
      data_valid_i = 1'b1;
      data_i = rnd96();
      sig_ready_i = $urandom_range(0, 1);
      @(negedge clkin);
      if (sig_o !== '0 || busy_o || sig_valid_o || rise_cnt_o !== '0)
        bad = 1'b1;
    end
    data_valid_i = 1'b0;
    sig_ready_i = 1'b0;
    chk("idle_no_change", W'(bad), '0);

    smp_q.push_back(96'h1);
    gap_q.push_back(0);
    run('0, 1, 0);
    chk("len1_sig", sig_o, 96'h1);
    chk("len1_rise", W'(rise_cnt_o), W'(1));

    smp_q.push_back(96'h80000000_00000000_00000000);
    smp_q.push_back('0);
    gap_q.push_back(0);
    gap_q.push_back(0);
    run('0, 2, 0);
    chk("poly_sig", sig_o, P);

    gap_q.push_back(0);
    gap_q.push_back(2);
    gap_q.push_back(0);
    run(rnd96(), 3, 4);

    run(96'hA5, 0, 1);
    chk("len0_sig", sig_o, 96'hA5);
    chk("len0_rise", W'(rise_cnt_o), '0);

    foreach (smp_q[i]) smp_q.delete(i);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] s;
      logic [5:0] pat;
      pat = 6'b101101;
      s = rnd96();
      s[0] = pat[i];
      smp_q.push_back(s);
    end
    run(rnd96(), 6, 0);
    chk("rise6", W'(rise_cnt_o), W'(3));

    @(posedge clkin); #1;
    start_i = 1'b1;
    len_i = CW'(6);
    seed_i = rnd96();
    @(posedge clkin); #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_valid_i = 1'b1;
      data_i = rnd96();
      @(posedge clkin); #1;
    end
    rst_n = 1'b0;
    #2;
    chk("abort_sig", sig_o, '0);
    chk("abort_rise", W'(rise_cnt_o), '0);
    chk("abort_busy", W'(busy_o), '0);
    @(posedge clkin); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      data_i = rnd96();
      sig_ready_i = 1'b1;
      @(negedge clkin);
      if (sig_valid_o || busy_o) bad = 1'b1;
      @(posedge clkin); #1;
    end
    data_valid_i = 1'b0;
    sig_ready_i = 1'b0;
    chk("abort_no_valid", W'(bad), '0);

    for (int r = 0; r < 20; r++) begin
      run(rnd96(), int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clkin);
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/out_signature_misr.md
Name: out_signature_misr

Overview:
Downstream capture stage for the fuzz-harness design under test. It consumes the DUT's 96-bit out_data stream and compacts a programmed number of samples into a 96-bit MISR signature. It also counts rising transitions of out_data[0], the async-set/reset flop output. The signature is offered to the bench/CXXRTL comparator through a valid/ready handshake, so simulator-vs-simulator mismatches reduce to one word plus one counter.

Parameters:
WIDTH, 96, sample and signature width (matches DUT out_data)
CNT_W, 16, width of the sample-length and rise counters
POLY, 96'h40000000_00028000_00000001, MISR feedback mask (x^96+x^94+x^49+x^47+1)

Ports:
clkin  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  begin a capture run (sampled only in IDLE)
len_i  input  CNT_W  number of samples to compact, latched at start
seed_i  input  WIDTH  initial MISR value, latched at start
data_valid_i  input  1  data_i carries a sample this cycle
data_i  input  WIDTH  DUT out_data
sig_valid_o  output  1  signature available
sig_ready_i  input  1  consumer accepts signature
sig_o  output  WIDTH  MISR signature
rise_cnt_o  output  CNT_W  count of 0->1 transitions of data_i[0] over accepted samples
busy_o  output  1  high in RUN or HOLD

Behaviour:
- Reset, async on rst_n low: state IDLE; sig_o=0; rise_cnt_o=0; sig_valid_o=0; busy_o=0; remaining=0; prev_bit=0. Reset in any state aborts the run. No sig_valid_o is produced for an aborted run.
- States: IDLE, RUN, HOLD.
- IDLE:
  - busy_o=0. sig_o and rise_cnt_o keep the previous result.
  - start_i=1: load sig=seed_i, remaining=len_i, rise_cnt=0, prev_bit=0.
  - Next state is RUN if len_i!=0. If len_i==0, next state is HOLD with sig=seed_i.
- RUN, on each cycle with data_valid_i=1:
  - sig <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ data_i.
  - rise_cnt increments when data_i[0]=1 and prev_bit=0. It saturates at all-ones.
  - prev_bit <= data_i[0].
  - remaining decrements.
  - A valid cycle with remaining==1 moves to HOLD. sig_valid_o rises the following cycle, so latency is 1 cycle after the final sample.
  - Cycles with data_valid_i=0 change nothing.
  - start_i is ignored.
- HOLD:
  - sig_valid_o=1. sig_o and rise_cnt_o are stable.
  - data_valid_i and start_i are ignored.
  - sig_valid_o & sig_ready_i: next state IDLE, and sig_valid_o drops the next cycle.
  - A start_i asserted in the same cycle as the handshake is ignored. A new run needs start_i in IDLE.
- sig_ready_i outside HOLD has no effect.
- Overflow: only rise_cnt saturates. remaining never underflows, because the exit happens at 1.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package `sig_pkg` holds:
  - the state enum (IDLE/RUN/HOLD)
  - the default POLY constant
  - the WIDTH=96 localparam, shared with the DUT harness
- One sub-module, `misr_reg`:
  - WIDTH-bit register with load (seed) and step enable (data, POLY)
  - async active-low reset to 0
- The FSM, the counters and rise detection stay in the top.

Test Plan:
1. Assert rst_n=0 mid-stream, then release -> all outputs 0, IDLE, busy_o=0. With start_i held low, no output changes.
2. seed=0, len=1, one sample 96'h1 -> sig_valid_o rises 1 cycle after the sample with sig_o=96'h1 and rise_cnt_o=1. Handshake -> IDLE, sig_o retained.
3. seed=0, len=2, samples 96'h80000000_00000000_00000000 then 0 -> sig_o=96'h40000000_00028000_00000001, which is POLY.
4. len=3 with valid pattern 1,0,0,1,1 and sig_ready_i low for 4 cycles:
   - sig_valid_o holds with sig_o stable.
   - start_i and data pulses during HOLD are ignored.
   - sig_valid_o falls the cycle after ready.
5. len=0, seed=96'hA5 -> HOLD next cycle with sig_o=96'hA5 and rise_cnt_o=0.
6. data_i[0] pattern 1,0,1,1,0,1 over len=6 -> rise_cnt_o=3. A repeated run with rst_n pulsed after 3 samples -> no sig_valid_o, counters 0.
